// File: rtl/mux8_arb_if.sv
// Bundle between the eight requesting channels and the round-robin mux arbiter.
// master = requester side (drives req/d), slave = arbiter side (drives sel/gnt/busy/y).
interface mux8_arb_if;
  logic [7:0] req;
  logic [7:0] d;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y;

  modport master (output req, d, input sel, gnt, busy, y);
  modport slave  (input req, d, output sel, gnt, busy, y);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 mux, with registered data output.
// Optional per-grant hold limit enabled by defining MUX8_ARB_HOLD_LIMIT_EN.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  mux8_arb_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       y_q, y_d;

  logic       release_c;
  logic [2:0] scan_ptr;
  logic [3:0] pick;

  // Returns {found, index}; lowest offset from p wins, wrapping 7->0.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam int HCNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(MAX_HOLD);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  assign release_c = !bus.req[sel_q] || (hcnt_q == HOLD_MAX);

  always_comb begin
    hcnt_d = hcnt_q;
    if (state_q == IDLE) begin
      if (pick[3]) hcnt_d = HCNT_W'(1);
    end else if (release_c) begin
      if (pick[3]) hcnt_d = HCNT_W'(1);
    end else if (hcnt_q != HOLD_MAX) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hcnt_q <= '0;
    else     hcnt_q <= hcnt_d;
  end
`else
  assign release_c = !bus.req[sel_q];
`endif

  // A released grantee is pushed to lowest priority by scanning from sel+1.
  assign scan_ptr = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
  assign pick     = rr_pick(bus.req, scan_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    y_d     = busy_q ? bus.d[sel_q] : 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick[3]) begin
          sel_d   = pick[2:0];
          gnt_d   = 8'b1 << pick[2:0];
          busy_d  = 1'b1;
          state_d = GRANT;
        end else begin
          gnt_d  = 8'h00;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d = scan_ptr;
          if (pick[3]) begin
            sel_d  = pick[2:0];
            gnt_d  = 8'b1 << pick[2:0];
            busy_d = 1'b1;
          end else begin
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'h00;
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.y    = y_q;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the shared 8:1 data multiplexer. Eight requesters contend for a single output line. The block grants one requester at a time, drives the 3-bit mux select, and registers the selected data bit. It sits between the requesting channels and the `mux8x1` datapath, whose `S` input it owns.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per requester when the hold limit is compiled in. Legal range 1..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request lines. `req[i]` high means requester i wants the output.
- `d` input 8: data lines `D0`–`D7`, one per requester.
- `sel` output 3: registered mux select; equals the index of the current grantee.
- `gnt` output 8: registered one-hot grant; all-zero when idle.
- `busy` output 1: registered; high while any grant is active.
- `y` output 1: registered mux output, `d[sel]` sampled while busy, else 0.

## Operation
- **Internal state:**
  - `state` ∈ {IDLE, GRANT}.
  - 3-bit priority pointer `ptr`.
  - Hold counter `hcnt`, width clog2(MAX_HOLD+1).
- **Arbitration function:**
  - Scan `req` starting at index `ptr`, ascending, wrapping 7→0.
  - The first set bit wins.
  - Search order is `ptr`, `ptr+1`, …, `ptr+7` (mod 8).
- **IDLE:**
  - If `req` == 0, stay in IDLE. `gnt`=0 and `busy`=0; `sel` holds its last value.
  - Otherwise load winner w: `sel`=w, `gnt`=1<<w, `busy`=1, `hcnt`=1, and go to GRANT.
- **GRANT:** the release condition is `req[sel]`==0, or (limit compiled in and `hcnt`==MAX_HOLD).
  - No release: hold `sel` and `gnt`; `hcnt` increments, saturating at MAX_HOLD.
  - Release: set `ptr` = `sel`+1 mod 8, then re-arbitrate in the same edge with the new pointer.
    - If a winner exists, load it directly: `hcnt`=1, stay in GRANT. This is a back-to-back handoff with no idle cycle.
    - If `req` == 0, go to IDLE with `gnt`=0 and `busy`=0.
  - A timed-out requester still asserting `req` has the lowest priority after release. It is re-granted immediately only if it is the sole requester.
- **Data path:** each edge, `y` ← `busy` ? `d[sel]` : 0, using pre-edge values. This is the `mux8x1` function applied to the registered select, then registered.
- **Reset values:** `sel`=0, `gnt`=0, `busy`=0, `y`=0, `ptr`=0, `hcnt`=0, `state`=IDLE.
- **Invariants:**
  - `gnt` is always zero or one-hot.
  - `gnt` != 0 ⇔ `busy` ⇔ `state`==GRANT.
  - When `busy`, `gnt`[`sel`]=1.

## Timing
- Request to grant: 1 cycle. `req` set before edge N gives `gnt` and `sel` valid after edge N.
- Grant to data: 1 cycle. `y` after edge N+1 reflects `d[sel]` sampled at edge N+1.
- Release on `req` drop: the drop seen at edge M releases at edge M. The next grantee's `sel` is valid after M, so there is no gap cycle.
- Hold limit: a continuous requester holds exactly MAX_HOLD cycles, edges N..N+MAX_HOLD-1. Release happens at the following edge.
- `ptr` changes only on release, never in IDLE. An IDLE→GRANT transition does not move `ptr`.
- Requests arriving or dropping on non-grantees during GRANT have no effect until release.
- `rst` high at any edge overrides all transitions, including mid-grant. All outputs take their reset values after that edge. The first arbitration after reset starts from `ptr`=0.
- `req` and `d` are sampled only at rising edges and are assumed synchronous to `clk`.

## Configuration
- `MUX8_ARB_HOLD_LIMIT_EN` defined:
  - A grant is forcibly released after MAX_HOLD cycles even if `req[sel]` stays high.
  - This guarantees every requester waits at most 7·MAX_HOLD cycles.
- Not defined:
  - A grant is held until `req[sel]` drops.
  - `hcnt` logic is compiled out, and `MAX_HOLD` is ignored.
  - Release occurs only on request drop.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles → `gnt`=0, `busy`=0, `sel`=0, `y`=0 throughout.
- From reset, `req`=8'h24 (bits 2, 5) held 1 cycle → after the edge `sel`=2, `gnt`=8'h04. Then drop `req[2]` → next edge `sel`=5, `gnt`=8'h20, no idle cycle. Drop all → `busy`=0, `ptr`=6.
- `req`=8'hFF continuous, limit enabled, MAX_HOLD=2 → `sel` sequence 0,0,1,1,2,2,…,7,7,0. `gnt` is one-hot every cycle.
- Same stimulus with the limit disabled → `sel` stays 0 indefinitely.
- Grant `sel`=3 with `d`=8'h08, then `d`=8'h00 → `y` is 1 one cycle after grant and 0 one cycle after the `d` change. `y`=0 one cycle after `busy` falls.
- Assert `rst` for one cycle while granted to requester 6 → after the edge all outputs are 0. With `req`=8'h41 the next arbitration grants 0 (`ptr`=0), not 6.
